// File: rtl/mips_mmu_top.sv
`default_nettype none
// ============================================================================
// Module   : mips_mmu_top
// Purpose  : MIPS32-style MMU with a combinational translation path. It
//            translates one instruction fetch address and one data address
//            per cycle through a 16-entry fully associative joint TLB. Each
//            entry maps an even/odd pair of 4 KB pages.
//            Address generation, the uncached attribute, exception flags and
//            the TLBP probe result are combinational. Only the TLB array
//            holds state.
// Ports    : clk, rst_n (synchronous, active-high: 1 = reset)
//            data_address_i / inst_address_i : virtual addresses
//            data_en / inst_en               : gate each port's exceptions
//            user_mode, asid, cp0_kseg0_uncached : CP0 state
//            tlb_config, tlbwi               : TLBWI write entry and strobe
//            tlbp, tlbp_result               : probe on the data address
//            data_/inst_address_o, *_uncached, *_exp_* : translation results
// Revision : 1.0 - initial release
// ============================================================================
module mips_mmu_top #(
    parameter int WITH_TLB = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data_address_i,
    input  logic [31:0] inst_address_i,
    input  logic        data_en,
    input  logic        inst_en,
    input  logic        user_mode,
    input  logic [7:0]  asid,
    input  logic        cp0_kseg0_uncached,
    input  logic [89:0] tlb_config,
    input  logic        tlbwi,
    input  logic        tlbp,
    output logic [31:0] data_address_o,
    output logic [31:0] inst_address_o,
    output logic        data_uncached,
    output logic        inst_uncached,
    output logic        data_exp_miss,
    output logic        inst_exp_miss,
    output logic        data_exp_illegal,
    output logic        inst_exp_illegal,
    output logic        data_exp_dirty,
    output logic        data_exp_invalid,
    output logic        inst_exp_invalid,
    output logic [31:0] tlbp_result
);

    localparam int          c_ENTRIES = 16;
    localparam logic [2:0]  c_CACHE_UNCACHED = 3'b010;
    localparam logic        c_TLB_ON = (WITH_TLB != 0);

    typedef struct packed {
        logic [31:0] pa;
        logic        unc;
        logic        miss;
        logic        inval;
        logic        dirty;
        logic        illegal;
    } xlate_t;

    // Lookup results for each port. The selected page fields have already
    // been chosen by va[12].
    logic        w_d_hit,  w_i_hit;
    logic [3:0]  w_d_idx,  w_i_idx;
    logic [19:0] w_d_pfn,  w_i_pfn;
    logic [2:0]  w_d_c,    w_i_c;
    logic        w_d_d,    w_i_d;
    logic        w_d_v,    w_i_v;

    // Translate one port. Illegal accesses suppress the TLB exceptions, but
    // the address is still produced normally.
    function automatic xlate_t f_xlate(
        input logic [31:0] va,
        input logic        en,
        input logic        is_data,
        input logic        hit,
        input logic [19:0] pfn,
        input logic [2:0]  c,
        input logic        d,
        input logic        v
    );
        xlate_t r;
        r         = '0;
        r.illegal = user_mode & va[31];
        if (va[31:30] == 2'b10) begin
            // kseg0 / kseg1: unmapped window onto the low 512 MB
            r.pa  = {3'b000, va[28:0]};
            r.unc = va[29] ? 1'b1 : cp0_kseg0_uncached;
        end else if (!c_TLB_ON) begin
            r.pa  = va;
        end else if (hit) begin
            r.pa  = {pfn, va[11:0]};
            r.unc = (c == c_CACHE_UNCACHED);
            if (!r.illegal) begin
                r.inval = ~v;
                r.dirty = is_data & v & ~d;
            end
        end else begin
            r.pa   = va;
            r.miss = ~r.illegal;
        end
        r.illegal = r.illegal & en;
        r.miss    = r.miss & en;
        r.inval   = r.inval & en;
        r.dirty   = r.dirty & en;
        return r;
    endfunction

    generate
        if (WITH_TLB != 0) begin : g_tlb
            logic                 r_present [c_ENTRIES];
            logic [18:0]          r_vpn2    [c_ENTRIES];
            logic [7:0]           r_asid    [c_ENTRIES];
            logic                 r_g       [c_ENTRIES];
            logic [19:0]          r_pfn0    [c_ENTRIES];
            logic [2:0]           r_c0      [c_ENTRIES];
            logic                 r_d0      [c_ENTRIES];
            logic                 r_v0      [c_ENTRIES];
            logic [19:0]          r_pfn1    [c_ENTRIES];
            logic [2:0]           r_c1      [c_ENTRIES];
            logic                 r_d1      [c_ENTRIES];
            logic                 r_v1      [c_ENTRIES];
            logic [3:0]           w_wr_idx;
            logic                 w_unused;

            assign w_wr_idx = tlb_config[89:86];
            assign w_unused = ^tlb_config[7:0];

            always_ff @(posedge clk) begin
                if (rst_n) begin
                    for (int i = 0; i < c_ENTRIES; i++) begin
                        r_present[i] <= 1'b0;
                        r_vpn2[i]    <= '0;
                        r_asid[i]    <= '0;
                        r_g[i]       <= 1'b0;
                        r_pfn0[i]    <= '0;
                        r_c0[i]      <= '0;
                        r_d0[i]      <= 1'b0;
                        r_v0[i]      <= 1'b0;
                        r_pfn1[i]    <= '0;
                        r_c1[i]      <= '0;
                        r_d1[i]      <= 1'b0;
                        r_v1[i]      <= 1'b0;
                    end
                end else if (tlbwi) begin
                    r_present[w_wr_idx] <= 1'b1;
                    r_vpn2[w_wr_idx]    <= tlb_config[85:67];
                    r_asid[w_wr_idx]    <= tlb_config[66:59];
                    r_g[w_wr_idx]       <= tlb_config[58];
                    r_pfn0[w_wr_idx]    <= tlb_config[57:38];
                    r_c0[w_wr_idx]      <= tlb_config[37:35];
                    r_d0[w_wr_idx]      <= tlb_config[34];
                    r_v0[w_wr_idx]      <= tlb_config[33];
                    r_pfn1[w_wr_idx]    <= tlb_config[32:13];
                    r_c1[w_wr_idx]      <= tlb_config[12:10];
                    r_d1[w_wr_idx]      <= tlb_config[9];
                    r_v1[w_wr_idx]      <= tlb_config[8];
                end
            end

            // The loop scans from the top index downwards, so the lowest
            // matching index is the one that is kept.
            always_comb begin
                w_d_hit = 1'b0;
                w_d_idx = '0;
                w_i_hit = 1'b0;
                w_i_idx = '0;
                for (int i = c_ENTRIES - 1; i >= 0; i--) begin
                    if (r_present[i] && r_vpn2[i] == data_address_i[31:13] &&
                        (r_g[i] || r_asid[i] == asid)) begin
                        w_d_hit = 1'b1;
                        w_d_idx = 4'(i);
                    end
                    if (r_present[i] && r_vpn2[i] == inst_address_i[31:13] &&
                        (r_g[i] || r_asid[i] == asid)) begin
                        w_i_hit = 1'b1;
                        w_i_idx = 4'(i);
                    end
                end
            end

            assign w_d_pfn = data_address_i[12] ? r_pfn1[w_d_idx] : r_pfn0[w_d_idx];
            assign w_d_c   = data_address_i[12] ? r_c1[w_d_idx]   : r_c0[w_d_idx];
            assign w_d_d   = data_address_i[12] ? r_d1[w_d_idx]   : r_d0[w_d_idx];
            assign w_d_v   = data_address_i[12] ? r_v1[w_d_idx]   : r_v0[w_d_idx];
            assign w_i_pfn = inst_address_i[12] ? r_pfn1[w_i_idx] : r_pfn0[w_i_idx];
            assign w_i_c   = inst_address_i[12] ? r_c1[w_i_idx]   : r_c0[w_i_idx];
            assign w_i_d   = inst_address_i[12] ? r_d1[w_i_idx]   : r_d0[w_i_idx];
            assign w_i_v   = inst_address_i[12] ? r_v1[w_i_idx]   : r_v0[w_i_idx];
        end else begin : g_no_tlb
            logic w_unused;
            assign w_unused = ^{clk, rst_n, asid, tlb_config, tlbwi};
            assign w_d_hit  = 1'b0;
            assign w_d_idx  = '0;
            assign w_i_hit  = 1'b0;
            assign w_i_idx  = '0;
            assign w_d_pfn  = '0;
            assign w_d_c    = '0;
            assign w_d_d    = 1'b0;
            assign w_d_v    = 1'b0;
            assign w_i_pfn  = '0;
            assign w_i_c    = '0;
            assign w_i_d    = 1'b0;
            assign w_i_v    = 1'b0;
        end
    endgenerate

    xlate_t w_dx, w_ix;
    logic   w_i_unused;

    assign w_dx = f_xlate(data_address_i, data_en, 1'b1, w_d_hit, w_d_pfn, w_d_c, w_d_d, w_d_v);
    assign w_ix = f_xlate(inst_address_i, inst_en, 1'b0, w_i_hit, w_i_pfn, w_i_c, w_i_d, w_i_v);
    // The fetch port never raises a dirty exception and does not report its index.
    assign w_i_unused = ^{w_ix.dirty, w_i_idx};

    assign data_address_o   = w_dx.pa;
    assign data_uncached    = w_dx.unc;
    assign data_exp_miss    = w_dx.miss;
    assign data_exp_illegal = w_dx.illegal;
    assign data_exp_dirty   = w_dx.dirty;
    assign data_exp_invalid = w_dx.inval;

    assign inst_address_o   = w_ix.pa;
    assign inst_uncached    = w_ix.unc;
    assign inst_exp_miss    = w_ix.miss;
    assign inst_exp_illegal = w_ix.illegal;
    assign inst_exp_invalid = w_ix.inval;

    // The probe ignores the segment and always uses the data-port lookup.
    assign tlbp_result = tlbp ? {~w_d_hit, 27'b0, w_d_idx} : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_mips_mmu_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_mmu_top
// Purpose  : Directed self-checking bench for mips_mmu_top. It drives two
//            instances: one with the TLB and one without.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_mmu_top;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] data_address_i, inst_address_i;
    logic        data_en, inst_en, user_mode, cp0_kseg0_uncached;
    logic [7:0]  asid;
    logic [89:0] tlb_config;
    logic        tlbwi, tlbp;

    logic [31:0] data_address_o, inst_address_o, tlbp_result;
    logic        data_uncached, inst_uncached, data_exp_miss, inst_exp_miss;
    logic        data_exp_illegal, inst_exp_illegal, data_exp_dirty;
    logic        data_exp_invalid, inst_exp_invalid;

    logic [31:0] n_data_address_o, n_inst_address_o, n_tlbp_result;
    logic        n_data_uncached, n_inst_uncached, n_data_exp_miss, n_inst_exp_miss;
    logic        n_data_exp_illegal, n_inst_exp_illegal, n_data_exp_dirty;
    logic        n_data_exp_invalid, n_inst_exp_invalid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_mmu_top #(.WITH_TLB(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .data_address_i(data_address_i), .inst_address_i(inst_address_i),
        .data_en(data_en), .inst_en(inst_en), .user_mode(user_mode),
        .asid(asid), .cp0_kseg0_uncached(cp0_kseg0_uncached),
        .tlb_config(tlb_config), .tlbwi(tlbwi), .tlbp(tlbp),
        .data_address_o(data_address_o), .inst_address_o(inst_address_o),
        .data_uncached(data_uncached), .inst_uncached(inst_uncached),
        .data_exp_miss(data_exp_miss), .inst_exp_miss(inst_exp_miss),
        .data_exp_illegal(data_exp_illegal), .inst_exp_illegal(inst_exp_illegal),
        .data_exp_dirty(data_exp_dirty), .data_exp_invalid(data_exp_invalid),
        .inst_exp_invalid(inst_exp_invalid), .tlbp_result(tlbp_result)
    );

    mips_mmu_top #(.WITH_TLB(0)) dut_notlb (
        .clk(clk), .rst_n(rst_n),
        .data_address_i(data_address_i), .inst_address_i(inst_address_i),
        .data_en(data_en), .inst_en(inst_en), .user_mode(user_mode),
        .asid(asid), .cp0_kseg0_uncached(cp0_kseg0_uncached),
        .tlb_config(tlb_config), .tlbwi(tlbwi), .tlbp(tlbp),
        .data_address_o(n_data_address_o), .inst_address_o(n_inst_address_o),
        .data_uncached(n_data_uncached), .inst_uncached(n_inst_uncached),
        .data_exp_miss(n_data_exp_miss), .inst_exp_miss(n_inst_exp_miss),
        .data_exp_illegal(n_data_exp_illegal), .inst_exp_illegal(n_inst_exp_illegal),
        .data_exp_dirty(n_data_exp_dirty), .data_exp_invalid(n_data_exp_invalid),
        .inst_exp_invalid(n_inst_exp_invalid), .tlbp_result(n_tlbp_result)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Build the tlb_config word without strobing tlbwi.
    task automatic set_entry(input logic [3:0] idx, input logic [18:0] vpn2,
                             input logic [7:0] ea, input logic g,
                             input logic [19:0] pfn0, input logic [2:0] c0,
                             input logic d0, input logic v0,
                             input logic [19:0] pfn1, input logic [2:0] c1,
                             input logic d1, input logic v1);
        tlb_config = {idx, vpn2, ea, g, pfn0, c0, d0, v0, pfn1, c1, d1, v1, 8'h00};
    endtask

    task automatic write_now();
        tlbwi = 1'b1;
        tick();
        tlbwi = 1'b0;
    endtask

    // Drive a data address and let the combinational path settle.
    task automatic dva(input logic [31:0] va);
        data_address_i = va;
        #1;
    endtask

    initial begin
        rst_n = 1'b1; data_address_i = '0; inst_address_i = '0;
        data_en = 1'b0; inst_en = 1'b0; user_mode = 1'b0; asid = '0;
        cp0_kseg0_uncached = 1'b0; tlb_config = '0; tlbwi = 1'b0; tlbp = 1'b0;
        tick(); tick();
        rst_n = 1'b0;

        // After reset, every mapped access misses, including VPN2 = 0.
        data_en = 1'b1; user_mode = 1'b1; tlbp = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dva(32'(i * 16));
            chk("rst_miss", {31'b0, data_exp_miss}, 32'h1);
            chk("rst_pa", data_address_o, 32'(i * 16));
            chk("rst_tlbp", tlbp_result, 32'h8000_0000);
            chk("rst_illegal", {31'b0, data_exp_illegal}, 32'h0);
            tick();
        end

        // Write entry 3. A lookup in the same cycle still sees the old contents.
        user_mode = 1'b0; asid = 8'h05;
        set_entry(4'd3, 19'h00001, 8'h05, 1'b0, 20'h12345, 3'd3, 1'b1, 1'b1,
                  20'h0ABCD, 3'd0, 1'b0, 1'b0);
        dva(32'h0000_2010);
        tlbwi = 1'b1;
        #1;
        chk("same_cycle_miss", {31'b0, data_exp_miss}, 32'h1);
        tick();
        tlbwi = 1'b0;
        #1;
        chk("hit_pa", data_address_o, 32'h1234_5010);
        chk("hit_exc", {28'b0, data_exp_miss, data_exp_invalid, data_exp_dirty, data_exp_illegal}, 32'h0);
        chk("hit_unc", {31'b0, data_uncached}, 32'h0);
        dva(32'h0000_3010);
        chk("odd_invalid", {31'b0, data_exp_invalid}, 32'h1);
        chk("odd_pa", data_address_o, 32'h0ABC_D010);
        chk("odd_miss", {31'b0, data_exp_miss}, 32'h0);
        dva(32'h0000_2000);
        chk("tlbp_hit", tlbp_result, 32'h0000_0003);
        tlbp = 1'b0;
        #1;
        chk("tlbp_idle", tlbp_result, 32'h0);
        tlbp = 1'b1;

        // An ASID mismatch misses. Rewriting the entry as global makes it hit.
        asid = 8'h06;
        dva(32'h0000_2010);
        chk("asid_miss", {31'b0, data_exp_miss}, 32'h1);
        chk("asid_miss_pa", data_address_o, 32'h0000_2010);
        chk("asid_tlbp", tlbp_result, 32'h8000_0000);
        set_entry(4'd3, 19'h00001, 8'h05, 1'b1, 20'h12345, 3'd3, 1'b1, 1'b1,
                  20'h0ABCD, 3'd0, 1'b0, 1'b0);
        write_now();
        chk("global_pa", data_address_o, 32'h1234_5010);
        chk("global_miss", {31'b0, data_exp_miss}, 32'h0);

        // Unmapped kseg0 and kseg1.
        cp0_kseg0_uncached = 1'b1;
        dva(32'h8000_1000);
        chk("kseg0_pa", data_address_o, 32'h0000_1000);
        chk("kseg0_unc", {31'b0, data_uncached}, 32'h1);
        cp0_kseg0_uncached = 1'b0;
        #1;
        chk("kseg0_cached", {31'b0, data_uncached}, 32'h0);
        dva(32'hA000_0040);
        chk("kseg1_pa", data_address_o, 32'h0000_0040);
        chk("kseg1_unc", {31'b0, data_uncached}, 32'h1);

        // Privilege errors in user mode.
        user_mode = 1'b1; inst_en = 1'b1; inst_address_i = 32'hBFC0_0000;
        #1;
        chk("inst_illegal", {31'b0, inst_exp_illegal}, 32'h1);
        chk("inst_kseg1_pa", inst_address_o, 32'h1FC0_0000);
        inst_en = 1'b0;
        #1;
        chk("inst_illegal_off", {31'b0, inst_exp_illegal}, 32'h0);
        dva(32'hC000_0000);
        chk("kseg2_illegal", {31'b0, data_exp_illegal}, 32'h1);
        chk("kseg2_nomiss", {31'b0, data_exp_miss}, 32'h0);
        user_mode = 1'b0;

        // A clean, uncached page gives a dirty exception on data only.
        set_entry(4'd5, 19'h00010, 8'h00, 1'b1, 20'h00777, 3'd2, 1'b0, 1'b1,
                  20'h0, 3'd0, 1'b0, 1'b0);
        write_now();
        dva(32'h0002_0008);
        inst_en = 1'b1; inst_address_i = 32'h0002_0008;
        #1;
        chk("dirty", {31'b0, data_exp_dirty}, 32'h1);
        chk("dirty_unc", {31'b0, data_uncached}, 32'h1);
        chk("dirty_pa", data_address_o, 32'h0077_7008);
        chk("inst_map_pa", inst_address_o, 32'h0077_7008);
        chk("inst_map_exc", {30'b0, inst_exp_miss, inst_exp_invalid}, 32'h0);
        chk("inst_map_unc", {31'b0, inst_uncached}, 32'h1);
        data_en = 1'b0;
        #1;
        chk("dirty_gated", {31'b0, data_exp_dirty}, 32'h0);
        data_en = 1'b1;

        // With duplicate entries, the lower index wins.
        set_entry(4'd7, 19'h00100, 8'h00, 1'b1, 20'h77777, 3'd3, 1'b1, 1'b1,
                  20'h0, 3'd0, 1'b0, 1'b0);
        write_now();
        set_entry(4'd2, 19'h00100, 8'h00, 1'b1, 20'h22222, 3'd3, 1'b1, 1'b1,
                  20'h0, 3'd0, 1'b0, 1'b0);
        write_now();
        dva(32'h0020_0000);
        chk("prio_pa", data_address_o, 32'h2222_2000);
        chk("prio_tlbp", tlbp_result, 32'h0000_0002);

        // Reset clears the array. A tlbwi held during reset is ignored.
        rst_n = 1'b1;
        set_entry(4'd9, 19'h00002, 8'h00, 1'b1, 20'h55555, 3'd3, 1'b1, 1'b1,
                  20'h0, 3'd0, 1'b0, 1'b0);
        write_now();
        rst_n = 1'b0;
        asid = 8'h05;
        dva(32'h0000_2010);
        chk("rst2_miss_a", {31'b0, data_exp_miss}, 32'h1);
        dva(32'h0020_0000);
        chk("rst2_miss_b", {31'b0, data_exp_miss}, 32'h1);
        chk("rst2_tlbp", tlbp_result, 32'h8000_0000);
        dva(32'h0000_4000);
        chk("rst2_wi_ignored", {31'b0, data_exp_miss}, 32'h1);

        // Fixed mapping when the TLB is absent.
        dva(32'h0040_0000);
        chk("notlb_pa", n_data_address_o, 32'h0040_0000);
        chk("notlb_miss", {31'b0, n_data_exp_miss}, 32'h0);
        chk("notlb_unc", {31'b0, n_data_uncached}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
